alu_exec_seq: RTL and testbench
===============================

# alu_exec_seq

Parametrised ALU control-and-execute stage for the CPU datapath. Decodes the 6-bit R-type function field and the 2-bit main-decoder `ALUctr` into an internal op, executes it on `WIDTH`-bit operands, and returns the result over a valid/ready handshake. Single-cycle ops complete in one cycle; an optional iterative multiply takes `WIDTH` cycles. Sits between the register-read stage and write-back, replacing the purely combinational op decoder plus ALU.

## Interface
- `WIDTH`, 32: operand/result width; must be ≥ 4.
- `SHAMT_W`, $clog2(WIDTH): shift-amount width (reserved; no shift ops in this revision).
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `in_valid` input 1: request present.
- `in_ready` output 1: stage can accept a request.
- `func` input 6: R-type function field.
- `alu_ctr` input 2: main-decoder ALU class.
- `op_a`, `op_b` input `WIDTH`: operands.
- `out_valid` output 1: result held and valid.
- `out_ready` input 1: consumer takes the result.
- `result` output `WIDTH`: result, low half for multiply.
- `result_hi` output `WIDTH`: high half of product; 0 for other ops.
- `zero` output 1: `result == 0`.
- `illegal` output 1: the accepted request did not decode; qualified by `out_valid`.

## Operation
- Decode at acceptance:
  - `alu_ctr` 00 → ADD.
  - `alu_ctr` 01 → SUB.
  - `alu_ctr` 11 → SLT (signed; result 1 or 0).
  - `alu_ctr` 10 → decode `func`: 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 100110 XOR, 011000 MUL (signed).
  - Any other `func` with `alu_ctr` 10 → `illegal`=1, `result`=0.
- Arithmetic wraps modulo 2^WIDTH; no overflow trap. SLT compares signed.
- MUL: signed 2·WIDTH-bit product. Iterative shift-add over `WIDTH` steps on operand magnitudes, with sign correction applied in the final step.
- FSM states:
  - IDLE: `in_ready`=1. Accept when `in_valid`. Single-cycle or illegal op → DONE. MUL → BUSY with counter = WIDTH−1.
  - BUSY: one step per cycle. At counter 0, load the product → DONE.
  - DONE: `out_valid`=1. Hold all outputs stable until `out_ready`, then go to IDLE.
- Inputs are captured at acceptance; later changes to `func`, `alu_ctr`, `op_a`, or `op_b` have no effect.
- Outputs reset to: `in_ready`=0 during reset (1 from the first cycle after release), `out_valid`=0, `result`=0, `result_hi`=0, `zero`=1, `illegal`=0. FSM resets to IDLE.
- Reset asserted mid-multiply or in DONE: result is discarded, state goes to IDLE immediately (asynchronous), counter is cleared.

## Timing
- Single-cycle op: accepted at edge N, `out_valid`=1 after edge N. Earliest next accept is one cycle after `out_ready`. Throughput is 1 op per 2 cycles with `out_ready` tied high.
- MUL: accepted at edge N, `out_valid`=1 after edge N+WIDTH.
- `in_ready` is low in BUSY and DONE. No back-to-back accept in the same cycle as result retirement.
- `out_valid` with `out_ready` low: the result holds indefinitely.
- All outputs are registered; no combinational path from inputs to outputs.

## Configuration
- `ALU_MUL_EN` defined: MUL decode, the BUSY state, the iteration counter, and the `alu_mul_iter` instance are compiled in.
- `ALU_MUL_EN` undefined: `func` 011000 decodes as illegal (one-cycle, `result`=0). The FSM never enters BUSY, and `result_hi` is tied to 0.

## Structure
- Package `alu_pkg`:
  - `func` constants (ADD, SUB, AND, OR, XOR, MUL).
  - `alu_ctr` class constants.
  - Internal op enum: ADD 3'b000, AND 3'b001, XOR 3'b010, SUB 3'b100, OR 3'b101, SLT 3'b110, MUL 3'b111.
  - FSM state enum (IDLE, BUSY, DONE).
- Sub-module `alu_mul_iter`: start/step/done shift-add multiplier, `WIDTH`-parametrised. Instantiated only under `ALU_MUL_EN`.

## Test plan
- Reset with `rst_n`=0 → `out_valid`=0, `result`=0, `zero`=1. After release, `in_ready`=1.
- `alu_ctr`=10, `func`=100010, `op_a`=5, `op_b`=7 (WIDTH 32) → one cycle later `result`=0xFFFFFFFE, `zero`=0, `illegal`=0. Result holds 3 cycles with `out_ready`=0, then retires.
- `alu_ctr`=11, `op_a`=0xFFFFFFFF, `op_b`=1 → `result`=1. Swap operands → `result`=0.
- `alu_ctr`=10, `func`=011000, `op_a`=−3, `op_b`=0x40000000, under `ALU_MUL_EN` → `out_valid` exactly 32 cycles after acceptance, `result`=0x40000000, `result_hi`=0xFFFFFFFF. `in_ready`=0 throughout.
- Same MUL without `ALU_MUL_EN` → `illegal`=1, `result`=0 after 1 cycle. `func`=111111 with `alu_ctr`=10 → `illegal`=1 in both builds.
- `rst_n` pulsed low at cycle 10 of a MUL → `out_valid` stays 0. A fresh ADD (2+3) afterwards gives `result`=5 after one cycle.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared decode constants, op/state encodings and the op decoder for alu_exec_seq.
// The MUL func decodes only when ALU_MUL_EN is defined.
package alu_pkg;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_XOR = 6'b100110;
  localparam logic [5:0] FN_MUL = 6'b011000;

  localparam logic [1:0] CTR_ADD  = 2'b00;
  localparam logic [1:0] CTR_SUB  = 2'b01;
  localparam logic [1:0] CTR_FUNC = 2'b10;
  localparam logic [1:0] CTR_SLT  = 2'b11;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_AND = 3'b001,
    OP_XOR = 3'b010,
    OP_SUB = 3'b100,
    OP_OR  = 3'b101,
    OP_SLT = 3'b110,
    OP_MUL = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  typedef struct packed {
    op_e  op;
    logic bad;
  } dec_t;

  function automatic dec_t decode(
    input logic [1:0] ctr,
    input logic [5:0] fn
  );
    dec_t d;
    d.op  = OP_ADD;
    d.bad = 1'b0;
    unique case (ctr)
      CTR_ADD: d.op = OP_ADD;
      CTR_SUB: d.op = OP_SUB;
      CTR_SLT: d.op = OP_SLT;
      CTR_FUNC: begin
        case (fn)
          FN_ADD: d.op = OP_ADD;
          FN_SUB: d.op = OP_SUB;
          FN_AND: d.op = OP_AND;
          FN_OR:  d.op = OP_OR;
          FN_XOR: d.op = OP_XOR;
`ifdef ALU_MUL_EN
          FN_MUL: d.op = OP_MUL;
`endif
          default: d.bad = 1'b1;
        endcase
      end
    endcase
    return d;
  endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative signed multiplier: shift-add on operand magnitudes, one bit per step.
// prod is the sign-corrected value the current step produces.
module alu_mul_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               step,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] prod
);

  logic [WIDTH-1:0]   mcand;
  logic [2*WIDTH-1:0] p;
  logic [2*WIDTH-1:0] p_nx;
  logic [WIDTH:0]     sum;
  logic               neg;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;

  assign mag_a = a[WIDTH-1] ? -a : a;
  assign mag_b = b[WIDTH-1] ? -b : b;

  always_comb begin
    sum  = {1'b0, p[2*WIDTH-1:WIDTH]}
         + (p[0] ? {1'b0, mcand} : '0);
    p_nx = {sum, p[WIDTH-1:1]};
    prod = neg ? -p_nx : p_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand <= '0;
      p     <= '0;
      neg   <= 1'b0;
    end else if (start) begin
      mcand <= mag_a;
      p     <= {{WIDTH{1'b0}}, mag_b};
      neg   <= a[WIDTH-1] ^ b[WIDTH-1];
    end else if (step) begin
      p <= p_nx;
    end
  end

endmodule

// File: rtl/alu_exec_seq.sv
// ALU control-and-execute stage with valid/ready handshake.
// Define ALU_MUL_EN to build in the iterative signed multiply.
module alu_exec_seq
  import alu_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [5:0]       func,
  input  logic [1:0]       alu_ctr,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             zero,
  output logic             illegal
);

  state_e           state;
  state_e           state_nx;
  dec_t             dec;
  logic [WIDTH-1:0] res;
  logic             accept;
  logic             is_mul;
  logic             cnt_zero;
  logic             ready_nx;
  logic             valid_nx;

  assign accept = in_valid & in_ready;
  assign dec    = decode(alu_ctr, func);

`ifdef ALU_MUL_EN
  logic [SHAMT_W-1:0] cnt;
  logic [2*WIDTH-1:0] prod;

  assign is_mul   = (dec.op == OP_MUL) & ~dec.bad;
  assign cnt_zero = (cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt <= '0;
    else if (accept & is_mul)
      cnt <= SHAMT_W'(WIDTH - 1);
    else if (state == S_BUSY && !cnt_zero)
      cnt <= cnt - 1'b1;
  end

  alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk   (clk),
    .rst_n (rst_n),
    .start (accept & is_mul),
    .step  (state == S_BUSY),
    .a     (op_a),
    .b     (op_b),
    .prod  (prod)
  );
`else
  assign is_mul   = 1'b0;
  assign cnt_zero = 1'b1;
`endif

  always_comb begin
    res = '0;
    unique case (dec.op)
      OP_ADD:  res = op_a + op_b;
      OP_SUB:  res = op_a - op_b;
      OP_AND:  res = op_a & op_b;
      OP_OR:   res = op_a | op_b;
      OP_XOR:  res = op_a ^ op_b;
      OP_SLT:  res = {{(WIDTH-1){1'b0}},
                      $signed(op_a) < $signed(op_b)};
      default: res = '0;
    endcase
    if (dec.bad)
      res = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      state     <= state_nx;
      in_ready  <= ready_nx;
      out_valid <= valid_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE: if (accept)
                state_nx = is_mul ? S_BUSY : S_DONE;
      S_BUSY: if (cnt_zero)
                state_nx = S_DONE;
      S_DONE: if (out_ready)
                state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // handshake flags are registered copies of the next state
  always_comb begin
    ready_nx = (state_nx == S_IDLE);
    valid_nx = (state_nx == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result    <= '0;
      result_hi <= '0;
      zero      <= 1'b1;
      illegal   <= 1'b0;
    end else if (accept) begin
      result    <= res;
      result_hi <= '0;
      zero      <= (res == '0);
      illegal   <= dec.bad;
    end
`ifdef ALU_MUL_EN
    else if (state == S_BUSY && cnt_zero) begin
      result    <= prod[WIDTH-1:0];
      result_hi <= prod[2*WIDTH-1:WIDTH];
      zero      <= (prod[WIDTH-1:0] == '0);
    end
`endif
  end

endmodule

// File: tb/tb_alu_exec_seq.sv
// Scoreboard bench for alu_exec_seq: driver pushes model results, monitor pops.
// Works in both the ALU_MUL_EN and default builds.
module tb_alu_exec_seq;

  localparam int W = 32;
`ifdef ALU_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [5:0]   func = '0;
  logic [1:0]   alu_ctr = '0;
  logic [W-1:0] op_a = '0;
  logic [W-1:0] op_b = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] result;
  logic [W-1:0] result_hi;
  logic         zero;
  logic         illegal;

  alu_exec_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .func      (func),
    .alu_ctr   (alu_ctr),
    .op_a      (op_a),
    .op_b      (op_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .result_hi (result_hi),
    .zero      (zero),
    .illegal   (illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] res;
    logic [W-1:0] hi;
    logic         zero;
    logic         ill;
    int           lat;
    int           acc;
    int           hold;
  } exp_t;

  exp_t q[$];
  exp_t cur;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   hold_cnt = 0;
  bit   pending = 1'b0;
  bit   mon_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference: plain arithmetic straight from the op table
  function automatic exp_t model(input logic [1:0] ctr,
                                 input logic [5:0] fn,
                                 input logic [W-1:0] a,
                                 input logic [W-1:0] b);
    exp_t   e;
    longint p;
    e.res = '0; e.hi = '0; e.ill = 1'b0;
    e.lat = 0; e.acc = 0; e.hold = 0;
    case (ctr)
      2'd0: e.res = a + b;
      2'd1: e.res = a - b;
      2'd3: e.res = ($signed(a) < $signed(b)) ? 1 : 0;
      default: begin
        case (fn)
          6'h20: e.res = a + b;
          6'h22: e.res = a - b;
          6'h24: e.res = a & b;
          6'h25: e.res = a | b;
          6'h26: e.res = a ^ b;
          6'h18: begin
            if (MUL_EN) begin
              p = longint'($signed(a)) * longint'($signed(b));
              e.res = p[31:0];
              e.hi  = p[63:32];
              e.lat = W;
            end else begin
              e.ill = 1'b1;
            end
          end
          default: e.ill = 1'b1;
        endcase
      end
    endcase
    e.zero = (e.res == 0);
    return e;
  endfunction

  task automatic issue(input logic [1:0] ctr, input logic [5:0] fn,
                       input logic [W-1:0] a, input logic [W-1:0] b,
                       input int hold, input bit push);
    int   n;
    exp_t e;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      chk("accept_timeout", in_ready, 1);
      return;
    end
    e = model(ctr, fn, a, b);
    e.hold = hold;
    e.acc = cyc + 1;
    alu_ctr = ctr; func = fn; op_a = a; op_b = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    alu_ctr = 2'($urandom);
    func = 6'($urandom);
    op_a = $urandom;
    op_b = $urandom;
    if (push) q.push_back(e);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q.size() > 0 || pending || out_valid) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("drain_queue", q.size(), 0);
  endtask

  always @(negedge clk) begin
    if (!mon_en) begin
      out_ready = 1'b0;
      pending = 1'b0;
    end else begin
      if ((q.size() > 0 || out_valid) && in_ready)
        chk("in_ready_low", in_ready, 0);
      if (out_valid) begin
        if (!pending) begin
          if (q.size() == 0) begin
            chk("unexpected_valid", out_valid, 0);
          end else begin
            cur = q.pop_front();
            pending = 1'b1;
            hold_cnt = 0;
            chk("latency", cyc - cur.acc, cur.lat);
          end
        end
        if (pending) begin
          chk("result", result, cur.res);
          chk("result_hi", result_hi, cur.hi);
          chk("zero", zero, cur.zero);
          chk("illegal", illegal, cur.ill);
          if (hold_cnt >= cur.hold) begin
            out_ready = 1'b1;
            pending = 1'b0;
          end else begin
            out_ready = 1'b0;
            hold_cnt++;
          end
        end else begin
          out_ready = 1'b1;
        end
      end else begin
        out_ready = 1'($urandom_range(0, 1));
      end
    end
  end

  function automatic logic [W-1:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return '0;
      1: return 1;
      2: return '1;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL watchdog checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] fns [6];
    logic [5:0] fn;
    bit         seen;
    fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h18};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_result", result, 0);
    chk("rst_result_hi", result_hi, 0);
    chk("rst_zero", zero, 1);
    chk("rst_illegal", illegal, 0);
    chk("rst_in_ready", in_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("in_ready_after_rst", in_ready, 1);
    mon_en = 1'b1;

    issue(2'b10, 6'b100010, 32'd5, 32'd7, 3, 1'b1);
    issue(2'b11, 6'd0, 32'hFFFF_FFFF, 32'd1, 0, 1'b1);
    issue(2'b11, 6'd0, 32'd1, 32'hFFFF_FFFF, 1, 1'b1);
    issue(2'b10, 6'b011000, 32'hFFFF_FFFD, 32'h4000_0000, 2, 1'b1);
    issue(2'b10, 6'b111111, 32'd9, 32'd4, 0, 1'b1);
    issue(2'b00, 6'd0, 32'hFFFF_FFFF, 32'd1, 0, 1'b1);
    drain();

    mon_en = 1'b0;
    issue(2'b10, 6'b011000, 32'hFFFF_FFFD, 32'h4000_0000, 0, 1'b0);
    repeat (9) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_result", result, 0);
    chk("midrst_result_hi", result_hi, 0);
    chk("midrst_zero", zero, 1);
    chk("midrst_in_ready", in_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    chk("midrst_no_valid", seen, 0);
    chk("midrst_idle", in_ready, 1);
    mon_en = 1'b1;
    issue(2'b00, 6'd0, 32'd2, 32'd3, 0, 1'b1);
    issue(2'b10, 6'b011000, 32'd7, 32'hFFFF_FFFA, 0, 1'b1);
    drain();

    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0)
        fn = 6'($urandom);
      else
        fn = fns[$urandom_range(0, 5)];
      issue(2'($urandom_range(0, 3)), fn, pick_operand(),
            pick_operand(), int'($urandom_range(0, 3)), 1'b1);
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
